// File: rtl/bank_ch_pkg.sv
// Shared types and defaults for the banked channel arbiter.
package bank_ch_pkg;

    typedef enum logic [0:0] {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    localparam int unsigned BANK_CH_NUM_DEF = 3;

    // Grant id width, never below one bit
    function automatic int unsigned bank_ch_id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bank_ch_prio_pick.sv
// Rotating priority encoder: first set request at or after i_base, wrapping N-1 -> 0.
module bank_ch_prio_pick
    import bank_ch_pkg::*;
#(
    parameter int unsigned N    = BANK_CH_NUM_DEF,
    parameter int unsigned ID_W = bank_ch_id_w(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_base,
    output logic            o_found,
    output logic [ID_W-1:0] o_idx
);

    // Scan from the farthest offset down so the nearest hit is written last
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int unsigned k = N; k > 0; k--) begin
            int unsigned v_pos;
            v_pos = 32'(i_base) + k - 1;
            if (v_pos >= N) begin
                v_pos = v_pos - N;
            end
            if (i_req[v_pos[ID_W-1:0]]) begin
                o_found = 1'b1;
                o_idx   = v_pos[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bank_ch_arb.sv
// Burst-aware channel-to-bank arbiter: round-robin or fixed priority, locks a channel until its last beat.
module bank_ch_arb
    import bank_ch_pkg::*;
#(
    parameter int unsigned CH_NUM   = BANK_CH_NUM_DEF,
    parameter int unsigned ID_W     = bank_ch_id_w(CH_NUM),
    parameter arb_mode_e   ARB_MODE = ARB_RR
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [CH_NUM-1:0] ch_req_valid_i,
    input  logic [CH_NUM-1:0] ch_req_last_i,
    output logic [CH_NUM-1:0] ch_req_ready_o,
    output logic              bank_valid_o,
    output logic [ID_W-1:0]   bank_id_o,
    output logic              bank_last_o,
    input  logic              bank_ready_i
);

    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(CH_NUM - 1);

    logic [ID_W-1:0] r_rr_ptr;
    logic            r_lock;
    logic [ID_W-1:0] r_lock_id;

    logic [ID_W-1:0] w_base;
    logic            w_found;
    logic [ID_W-1:0] w_pick;
    logic [ID_W-1:0] w_cand;
    logic            w_valid;
    logic            w_xfer;
    logic [ID_W-1:0] w_next_ptr;

    assign w_base = (ARB_MODE == ARB_FIXED) ? '0 : r_rr_ptr;

    bank_ch_prio_pick #(
        .N    (CH_NUM),
        .ID_W (ID_W)
    ) u_pick (
        .i_req   (ch_req_valid_i),
        .i_base  (w_base),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    // Grant is gated by reset so an abandoned burst drops off the bank at once
    assign w_cand     = r_lock ? r_lock_id : w_pick;
    assign w_valid    = rstn_i & (r_lock ? ch_req_valid_i[r_lock_id] : w_found);
    assign w_xfer     = w_valid & bank_ready_i;
    assign w_next_ptr = (w_cand == LAST_IDX) ? '0 : w_cand + ID_W'(1);

    assign bank_valid_o = w_valid;
    assign bank_id_o    = w_valid ? w_cand : '0;
    assign bank_last_o  = w_valid & ch_req_last_i[w_cand];

    always_comb begin
        ch_req_ready_o = '0;
        if (w_xfer) begin
            ch_req_ready_o[w_cand] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rr_ptr  <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
        end else if (w_xfer) begin
            if (ch_req_last_i[w_cand]) begin
                r_lock <= 1'b0;
                if (ARB_MODE == ARB_RR) begin
                    r_rr_ptr <= w_next_ptr;
                end
            end else begin
                r_lock    <= 1'b1;
                r_lock_id <= w_cand;
            end
        end
    end

endmodule

// File: tb/tb_bank_ch_arb.sv
// Directed bench for bank_ch_arb: table of single-cycle vectors plus hand sequences.
module tb_bank_ch_arb;
    import bank_ch_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Instance A: CH_NUM=3 round-robin
    logic [2:0] a_valid = '0, a_last = '0, a_rdy;
    logic       a_ready = 1'b0, a_bv, a_bl;
    logic [1:0] a_id;
    // Instance B: CH_NUM=4 round-robin
    logic [3:0] b_valid = '0, b_last = '0, b_rdy;
    logic       b_ready = 1'b0, b_bv, b_bl;
    logic [1:0] b_id;
    // Instance F: CH_NUM=3 fixed priority
    logic [2:0] f_valid = '0, f_last = '0, f_rdy;
    logic       f_ready = 1'b0, f_bv, f_bl;
    logic [1:0] f_id;

    bank_ch_arb #(.CH_NUM(3), .ARB_MODE(ARB_RR)) dut_a (
        .clk_i(clk), .rstn_i(rstn), .ch_req_valid_i(a_valid), .ch_req_last_i(a_last),
        .ch_req_ready_o(a_rdy), .bank_valid_o(a_bv), .bank_id_o(a_id),
        .bank_last_o(a_bl), .bank_ready_i(a_ready));

    bank_ch_arb #(.CH_NUM(4), .ARB_MODE(ARB_RR)) dut_b (
        .clk_i(clk), .rstn_i(rstn), .ch_req_valid_i(b_valid), .ch_req_last_i(b_last),
        .ch_req_ready_o(b_rdy), .bank_valid_o(b_bv), .bank_id_o(b_id),
        .bank_last_o(b_bl), .bank_ready_i(b_ready));

    bank_ch_arb #(.CH_NUM(3), .ARB_MODE(ARB_FIXED)) dut_f (
        .clk_i(clk), .rstn_i(rstn), .ch_req_valid_i(f_valid), .ch_req_last_i(f_last),
        .ch_req_ready_o(f_rdy), .bank_valid_o(f_bv), .bank_id_o(f_id),
        .bank_last_o(f_bl), .bank_ready_i(f_ready));

    typedef struct {
        logic [2:0] v;
        logic [2:0] l;
        logic       r;
        logic       ev;
        logic [1:0] eid;
        logic       el;
        logic [2:0] erdy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Inputs, expected {valid, id, last, ready} per cycle on instance A
        tbl.push_back('{3'b000, 3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000});
        tbl.push_back('{3'b111, 3'b111, 1'b1, 1'b1, 2'd0, 1'b1, 3'b001});
        tbl.push_back('{3'b111, 3'b111, 1'b1, 1'b1, 2'd1, 1'b1, 3'b010});
        tbl.push_back('{3'b111, 3'b111, 1'b1, 1'b1, 2'd2, 1'b1, 3'b100});
        tbl.push_back('{3'b111, 3'b111, 1'b1, 1'b1, 2'd0, 1'b1, 3'b001});
        tbl.push_back('{3'b111, 3'b111, 1'b1, 1'b1, 2'd1, 1'b1, 3'b010});
        tbl.push_back('{3'b111, 3'b111, 1'b1, 1'b1, 2'd2, 1'b1, 3'b100});
        tbl.push_back('{3'b001, 3'b001, 1'b1, 1'b1, 2'd0, 1'b1, 3'b001});
        tbl.push_back('{3'b111, 3'b000, 1'b1, 1'b1, 2'd1, 1'b0, 3'b010});
        tbl.push_back('{3'b111, 3'b000, 1'b1, 1'b1, 2'd1, 1'b0, 3'b010});
        tbl.push_back('{3'b111, 3'b010, 1'b1, 1'b1, 2'd1, 1'b1, 3'b010});
        tbl.push_back('{3'b111, 3'b111, 1'b1, 1'b1, 2'd2, 1'b1, 3'b100});
        tbl.push_back('{3'b111, 3'b111, 1'b1, 1'b1, 2'd0, 1'b1, 3'b001});
        tbl.push_back('{3'b111, 3'b111, 1'b0, 1'b1, 2'd1, 1'b1, 3'b000});
        tbl.push_back('{3'b111, 3'b111, 1'b0, 1'b1, 2'd1, 1'b1, 3'b000});
        tbl.push_back('{3'b111, 3'b111, 1'b1, 1'b1, 2'd1, 1'b1, 3'b010});
        tbl.push_back('{3'b101, 3'b000, 1'b1, 1'b1, 2'd2, 1'b0, 3'b100});
        tbl.push_back('{3'b001, 3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000});
        tbl.push_back('{3'b001, 3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000});
        tbl.push_back('{3'b101, 3'b100, 1'b1, 1'b1, 2'd2, 1'b1, 3'b100});
        tbl.push_back('{3'b001, 3'b001, 1'b1, 1'b1, 2'd0, 1'b1, 3'b001});

        // Outputs during reset, even with requests present
        a_valid = 3'b111; a_last = 3'b111; a_ready = 1'b1;
        #2;
        chk("rst_a_valid", 32'(a_bv), 32'd0);
        chk("rst_a_ready", 32'(a_rdy), 32'd0);
        chk("rst_a_id", 32'(a_id), 32'd0);
        chk("rst_a_last", 32'(a_bl), 32'd0);
        a_valid = '0; a_last = '0;
        #10 rstn = 1'b1;
        next_cycle();

        for (int i = 0; i < tbl.size(); i++) begin
            a_valid = tbl[i].v; a_last = tbl[i].l; a_ready = tbl[i].r;
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 32'(a_bv), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_id", i), 32'(a_id), 32'(tbl[i].eid));
            chk($sformatf("vec%0d_last", i), 32'(a_bl), 32'(tbl[i].el));
            chk($sformatf("vec%0d_ready", i), 32'(a_rdy), 32'(tbl[i].erdy));
            next_cycle();
        end
        a_valid = '0; a_last = '0;

        // CH_NUM=4: move pointer to 3, then stall with ch0/ch1 requesting
        b_valid = 4'b0100; b_last = 4'b0100; b_ready = 1'b1;
        @(negedge clk);
        chk("b_ptr3_id", 32'(b_id), 32'd2);
        next_cycle();
        b_valid = 4'b0011; b_last = 4'b0011; b_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("b_stall_valid", 32'(b_bv), 32'd1);
            chk("b_stall_id", 32'(b_id), 32'd0);
            chk("b_stall_ready", 32'(b_rdy), 32'd0);
            next_cycle();
        end
        b_ready = 1'b1;
        @(negedge clk);
        chk("b_xfer_ready", 32'(b_rdy), 32'b0001);
        next_cycle();
        b_valid = 4'b1111; b_last = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("b_rot_id", 32'(b_id), 32'((c + 1) % 4));
            next_cycle();
        end
        b_valid = '0; b_last = '0;

        // Fixed priority: ch1 always wins over ch2
        f_valid = 3'b110; f_last = 3'b110; f_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("f_prio_id", 32'(f_id), 32'd1);
            chk("f_prio_ready", 32'(f_rdy), 32'b010);
            next_cycle();
        end
        f_valid = 3'b011; f_last = 3'b000;
        @(negedge clk);
        chk("f_lock_id", 32'(f_id), 32'd0);
        next_cycle();
        f_valid = 3'b110; f_last = 3'b110;
        @(negedge clk);
        chk("f_lock_hold_valid", 32'(f_bv), 32'd0);
        chk("f_lock_hold_ready", 32'(f_rdy), 32'd0);
        next_cycle();
        f_valid = 3'b011; f_last = 3'b001;
        @(negedge clk);
        chk("f_lock_end_ready", 32'(f_rdy), 32'b001);
        chk("f_lock_end_last", 32'(f_bl), 32'd1);
        next_cycle();
        f_valid = '0; f_last = '0;

        // Reset mid-burst on ch1 (pointer is 1 here)
        a_valid = 3'b010; a_last = 3'b000; a_ready = 1'b1;
        @(negedge clk);
        chk("rb_first_ready", 32'(a_rdy), 32'b010);
        next_cycle();
        a_valid = 3'b111;
        @(negedge clk);
        chk("rb_locked_id", 32'(a_id), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("rb_valid_drop", 32'(a_bv), 32'd0);
        chk("rb_ready_drop", 32'(a_rdy), 32'd0);
        chk("rb_id_drop", 32'(a_id), 32'd0);
        next_cycle();
        chk("rb_hold_valid", 32'(a_bv), 32'd0);
        #2 rstn = 1'b1;
        a_last = 3'b111;
        #1;
        chk("rb_restart_valid", 32'(a_bv), 32'd1);
        chk("rb_restart_id", 32'(a_id), 32'd0);
        chk("rb_restart_ready", 32'(a_rdy), 32'b001);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
